// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: pin sync, clock glitch filter, 11-bit deserialiser, F0/E0 prefix folding.
// Optional PS2_PARITY_CHECK_EN: reject frames with even parity or a low stop bit.
//
// state    | meaning
// S_IDLE   | waiting for a start bit (data low on a filtered falling edge)
// S_DATA   | shifting 8 data bits, LSB first
// S_PARITY | capturing the parity bit
// S_STOP   | capturing the stop bit, then evaluating the byte
module ps2_frame_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 16384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] keycode,
  output logic        oflag
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t state, state_nxt;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt_clk, filt_clk_d1;
  logic [FW-1:0] filt_cnt;
  logic [TW-1:0] to_cnt;
  logic [7:0]    shift;
  logic [2:0]    bit_cnt;
  logic          brk;
  logic          fall, to_hit;
  logic          start, shift_en, par_en, frame_done, timeout;
  logic          accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // Filtered level only moves after FILTER_LEN back-to-back disagreeing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_clk    <= 1'b1;
      filt_clk_d1 <= 1'b1;
      filt_cnt    <= '0;
    end else begin
      filt_clk_d1 <= filt_clk;
      if (clk_s2 == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_MAX) begin
        filt_clk <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign fall   = filt_clk_d1 & ~filt_clk;
  assign to_hit = (to_cnt == TO_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (state == S_IDLE || fall) begin
      to_cnt <= '0;
    end else if (!to_hit) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    start      = 1'b0;
    shift_en   = 1'b0;
    par_en     = 1'b0;
    frame_done = 1'b0;
    timeout    = 1'b0;
    case (state)
      S_IDLE: begin
        if (fall && !dat_s2) begin
          start     = 1'b1;
          state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (fall) begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) state_nxt = S_PARITY;
        end else if (to_hit) begin
          timeout   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_PARITY: begin
        if (fall) begin
          par_en    = 1'b1;
          state_nxt = S_STOP;
        end else if (to_hit) begin
          timeout   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_STOP: begin
        if (fall) begin
          frame_done = 1'b1;
          state_nxt  = S_IDLE;
        end else if (to_hit) begin
          timeout   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef PS2_PARITY_CHECK_EN
  logic par_bit;

  always_ff @(posedge clk) begin
    if (rst) begin
      par_bit <= 1'b0;
    end else if (par_en) begin
      par_bit <= dat_s2;
    end
  end

  // dat_s2 is the stop bit on the cycle frame_done is asserted.
  assign accept = (^{shift, par_bit}) & dat_s2;
`else
  assign accept = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      shift   <= '0;
      bit_cnt <= '0;
    end else if (start || timeout) begin
      shift   <= '0;
      bit_cnt <= '0;
    end else if (shift_en) begin
      shift   <= {dat_s2, shift[7:1]};
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      keycode <= 16'h0000;
      oflag   <= 1'b0;
      brk     <= 1'b0;
    end else begin
      oflag <= 1'b0;
      if (frame_done) begin
        if (!accept) begin
          brk <= 1'b0;
        end else if (shift == 8'hF0) begin
          brk <= 1'b1;
        end else if (shift != 8'hE0) begin
          keycode <= {(brk ? 8'hF0 : 8'h00), shift};
          oflag   <= 1'b1;
          brk     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Directed bench for ps2_frame_rx: bit-banged PS/2 frames, per-scenario tasks with inline checks.
module tb_ps2_frame_rx;

  localparam int FL   = 8;
  localparam int TO   = 1024;
  localparam int HALF = 20;
  localparam int GAP  = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [15:0] keycode;
  logic        oflag;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int dbl_cnt = 0;
  int last_pulse_cyc = 0;
  int stop_edge_cyc = 0;
  logic [15:0] last_kc = 16'h0000;
  logic prev_oflag = 1'b0;

  ps2_frame_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .keycode(keycode), .oflag(oflag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (oflag) begin
      pulse_cnt = pulse_cnt + 1;
      last_kc = keycode;
      last_pulse_cyc = cyc;
      if (prev_oflag) dbl_cnt = dbl_cnt + 1;
    end
    prev_oflag = oflag;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends the first nbits of a frame; a glitch of FL-1 cycles is placed before bit glitch_idx.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits, input int glitch_idx);
    logic [10:0] bits;
    bits = {1'b1, (bad_par ? ^b : ~^b), b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      if (i == glitch_idx) begin
        tick(4);
        ps2_clk = 1'b0;
        tick(FL - 1);
        ps2_clk = 1'b1;
        tick(HALF - 4 - (FL - 1));
      end else begin
        tick(HALF);
      end
      if (i == 10) stop_edge_cyc = cyc;
      ps2_clk = 1'b0;
      tick(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    tick(GAP);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(5);
    tests++;
    if (keycode !== 16'h0000) begin
      fails++; $display("FAIL reset_keycode got %h want %h", keycode, 16'h0000);
    end
    tests++;
    if (oflag !== 1'b0) begin
      fails++; $display("FAIL reset_oflag got %b want 0", oflag);
    end
    rst = 1'b0;
    tick(5);
  endtask

  task automatic test_single_make();
    int p0;
    p0 = pulse_cnt;
    send_frame(8'h29, 1'b0, 11, -1);
    tests++;
    if (pulse_cnt - p0 != 1) begin
      fails++; $display("FAIL make_pulses got %0d want 1", pulse_cnt - p0);
    end
    tests++;
    if (last_kc !== 16'h0029) begin
      fails++; $display("FAIL make_keycode got %h want 0029", last_kc);
    end
    tests++;
    if (last_pulse_cyc - stop_edge_cyc != FL + 3) begin
      fails++; $display("FAIL make_latency got %0d want %0d", last_pulse_cyc - stop_edge_cyc, FL + 3);
    end
    tests++;
    if (keycode !== 16'h0029) begin
      fails++; $display("FAIL make_hold got %h want 0029", keycode);
    end
  endtask

  task automatic test_reset_mid_frame();
    int p0;
    send_frame(8'h1C, 1'b0, 11, -1);
    send_frame(8'h29, 1'b0, 5, -1);
    rst = 1'b1;
    tick(3);
    tests++;
    if (keycode !== 16'h0000) begin
      fails++; $display("FAIL midrst_keycode got %h want 0000", keycode);
    end
    tests++;
    if (oflag !== 1'b0) begin
      fails++; $display("FAIL midrst_oflag got %b want 0", oflag);
    end
    rst = 1'b0;
    tick(10);
    p0 = pulse_cnt;
    send_frame(8'h29, 1'b0, 11, -1);
    tests++;
    if (pulse_cnt - p0 != 1 || last_kc !== 16'h0029) begin
      fails++; $display("FAIL midrst_next got %0d/%h want 1/0029", pulse_cnt - p0, last_kc);
    end
  endtask

  task automatic test_prefix();
    int p0;
    p0 = pulse_cnt;
    send_frame(8'hF0, 1'b0, 11, -1);
    tests++;
    if (pulse_cnt != p0) begin
      fails++; $display("FAIL f0_nopulse got %0d want 0", pulse_cnt - p0);
    end
    send_frame(8'h23, 1'b0, 11, -1);
    tests++;
    if (pulse_cnt - p0 != 1 || last_kc !== 16'hF023) begin
      fails++; $display("FAIL break_23 got %0d/%h want 1/F023", pulse_cnt - p0, last_kc);
    end
    send_frame(8'h1C, 1'b0, 11, -1);
    tests++;
    if (pulse_cnt - p0 != 2 || last_kc !== 16'h001C) begin
      fails++; $display("FAIL make_1c got %0d/%h want 2/001C", pulse_cnt - p0, last_kc);
    end
    p0 = pulse_cnt;
    send_frame(8'hE0, 1'b0, 11, -1);
    send_frame(8'hF0, 1'b0, 11, -1);
    send_frame(8'h74, 1'b0, 11, -1);
    tests++;
    if (pulse_cnt - p0 != 1 || last_kc !== 16'hF074) begin
      fails++; $display("FAIL ext_break got %0d/%h want 1/F074", pulse_cnt - p0, last_kc);
    end
    p0 = pulse_cnt;
    send_frame(8'hF0, 1'b0, 11, -1);
    send_frame(8'hF0, 1'b0, 11, -1);
    send_frame(8'h23, 1'b0, 11, -1);
    send_frame(8'h23, 1'b0, 11, -1);
    tests++;
    if (pulse_cnt - p0 != 2 || last_kc !== 16'h0023) begin
      fails++; $display("FAIL f0f0 got %0d/%h want 2/0023", pulse_cnt - p0, last_kc);
    end
  endtask

  task automatic test_glitch();
    int p0;
    p0 = pulse_cnt;
    send_frame(8'h1C, 1'b0, 11, 4);
    tests++;
    if (pulse_cnt - p0 != 1) begin
      fails++; $display("FAIL glitch_pulses got %0d want 1", pulse_cnt - p0);
    end
    tests++;
    if (last_kc !== 16'h001C) begin
      fails++; $display("FAIL glitch_keycode got %h want 001C", last_kc);
    end
  endtask

  task automatic test_timeout();
    int p0;
    p0 = pulse_cnt;
    send_frame(8'h23, 1'b0, 5, -1);
    tick(TO);
    send_frame(8'h1C, 1'b0, 11, -1);
    tests++;
    if (pulse_cnt - p0 != 1) begin
      fails++; $display("FAIL timeout_pulses got %0d want 1", pulse_cnt - p0);
    end
    tests++;
    if (last_kc !== 16'h001C) begin
      fails++; $display("FAIL timeout_keycode got %h want 001C", last_kc);
    end
  endtask

  task automatic test_parity();
    int p0;
    p0 = pulse_cnt;
`ifdef PS2_PARITY_CHECK_EN
    send_frame(8'hF0, 1'b0, 11, -1);
    send_frame(8'h29, 1'b1, 11, -1);
    tests++;
    if (pulse_cnt != p0) begin
      fails++; $display("FAIL parity_reject got %0d want 0", pulse_cnt - p0);
    end
    send_frame(8'h23, 1'b0, 11, -1);
    tests++;
    if (pulse_cnt - p0 != 1 || last_kc !== 16'h0023) begin
      fails++; $display("FAIL parity_brk_clear got %0d/%h want 1/0023", pulse_cnt - p0, last_kc);
    end
`else
    send_frame(8'h29, 1'b1, 11, -1);
    tests++;
    if (pulse_cnt - p0 != 1) begin
      fails++; $display("FAIL parity_ignored got %0d want 1", pulse_cnt - p0);
    end
    tests++;
    if (last_kc !== 16'h0029) begin
      fails++; $display("FAIL parity_keycode got %h want 0029", last_kc);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int p0;
    p0 = pulse_cnt;
    send_frame(8'h1C, 1'b0, 11, -1);
    send_frame(8'h1C, 1'b0, 11, -1);
    send_frame(8'h1C, 1'b0, 11, -1);
    tests++;
    if (pulse_cnt - p0 != 3 || last_kc !== 16'h001C) begin
      fails++; $display("FAIL repeats got %0d/%h want 3/001C", pulse_cnt - p0, last_kc);
    end
    tests++;
    if (dbl_cnt != 0) begin
      fails++; $display("FAIL pulse_width got %0d double pulses want 0", dbl_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_make();
    test_reset_mid_frame();
    test_prefix();
    test_glitch();
    test_timeout();
    test_parity();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
